// File: rtl/regfile_param_if.sv
// Decode/writeback <-> register file bus: two read ports, issue port, writeback port.
// master = pipeline side, slave = regfile_param.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] Rd1;
    logic [DATA_W-1:0] Rd2;
    logic              Busy1;
    logic              Busy2;
    logic              Issue_Valid;
    logic [ADDR_W-1:0] Issue_rd;
    logic              Write_Enable;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] Write_Data;
    logic              Pending_Any;

    modport master (
        output rs1, rs2, Issue_Valid, Issue_rd, Write_Enable, rd, Write_Data,
        input  Rd1, Rd2, Busy1, Busy2, Pending_Any
    );

    modport slave (
        input  rs1, rs2, Issue_Valid, Issue_rd, Write_Enable, rd, Write_Data,
        output Rd1, Rd2, Busy1, Busy2, Pending_Any
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file (x0 hardwired to zero) with a per-register pending-write scoreboard.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input logic          Clk,
    input logic          Rst,
    regfile_param_if.slave bus
);

    logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] pend_q;
    logic [NUM_REGS-1:1] pend_d;

    logic                wr_en;
    logic [DATA_W-1:0]   rd1_c;
    logic [DATA_W-1:0]   rd2_c;
    logic                busy1_c;
    logic                busy2_c;

    assign wr_en = bus.Write_Enable && (bus.rd != '0);

    // Issue wins over writeback on the same register: the newer producer is still outstanding.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            pend_d[r] = pend_q[r];
            if (wr_en && (bus.rd == ADDR_W'(r))) begin
                regs_d[r] = bus.Write_Data;
                pend_d[r] = 1'b0;
            end
            if (bus.Issue_Valid && (bus.Issue_rd == ADDR_W'(r))) begin
                pend_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rd1_c   = '0;
        rd2_c   = '0;
        busy1_c = 1'b0;
        busy2_c = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.rs1 == ADDR_W'(r)) begin
                rd1_c   = regs_q[r];
                busy1_c = pend_q[r];
            end
            if (bus.rs2 == ADDR_W'(r)) begin
                rd2_c   = regs_q[r];
                busy2_c = pend_q[r];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback; held off during reset so outputs stay zero.
        if (!Rst && wr_en && (bus.rs1 == bus.rd)) begin
            rd1_c   = bus.Write_Data;
            busy1_c = 1'b0;
        end
        if (!Rst && wr_en && (bus.rs2 == bus.rd)) begin
            rd2_c   = bus.Write_Data;
            busy2_c = 1'b0;
        end
`endif
    end

    assign bus.Rd1         = rd1_c;
    assign bus.Rd2         = rd2_c;
    assign bus.Busy1       = busy1_c;
    assign bus.Busy2       = busy2_c;
    assign bus.Pending_Any = |pend_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized traffic
// against an array-based reference model; a second 64x16 instance covers the parameters.
module tb_regfile_param;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_param_if #(.DATA_W(64), .ADDR_W(4)) bus2 ();

    regfile_param #(.DATA_W(32), .NUM_REGS(32)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
    regfile_param #(.DATA_W(64), .NUM_REGS(16)) dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2));

    int total = 0;
    int bad   = 0;

    logic [31:0] m_reg  [32];
    bit          m_pend [32];
    logic [63:0] m2_reg [16];
    bit          m2_pend[16];

    logic [66:0] obs;
    logic [66:0] exp_v;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin m2_reg[i] = '0; m2_pend[i] = 1'b0; end
    endtask

    task automatic idle();
        bus.rs1 = '0; bus.rs2 = '0; bus.Issue_Valid = 1'b0; bus.Issue_rd = '0;
        bus.Write_Enable = 1'b0; bus.rd = '0; bus.Write_Data = '0;
        bus2.rs1 = '0; bus2.rs2 = '0; bus2.Issue_Valid = 1'b0; bus2.Issue_rd = '0;
        bus2.Write_Enable = 1'b0; bus2.rd = '0; bus2.Write_Data = '0;
    endtask

    // Advance one clock, applying the architectural rules to the model; returns at edge+1.
    task automatic tick();
        @(posedge Clk);
        if (!Rst) begin
            if (bus.Write_Enable && bus.rd != 0) begin
                m_reg[bus.rd] = bus.Write_Data; m_pend[bus.rd] = 1'b0;
            end
            if (bus.Issue_Valid && bus.Issue_rd != 0) m_pend[bus.Issue_rd] = 1'b1;
            if (bus2.Write_Enable && bus2.rd != 0) begin
                m2_reg[bus2.rd] = bus2.Write_Data; m2_pend[bus2.rd] = 1'b0;
            end
            if (bus2.Issue_Valid && bus2.Issue_rd != 0) m2_pend[bus2.Issue_rd] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [66:0] exp_main();
        logic [31:0] e1, e2;
        logic b1, b2, pa;
        e1 = (bus.rs1 == 0) ? 32'd0 : m_reg[bus.rs1];
        e2 = (bus.rs2 == 0) ? 32'd0 : m_reg[bus.rs2];
        b1 = (bus.rs1 == 0) ? 1'b0 : m_pend[bus.rs1];
        b2 = (bus.rs2 == 0) ? 1'b0 : m_pend[bus.rs2];
        pa = 1'b0;
        for (int i = 1; i < 32; i++) pa = pa | m_pend[i];
`ifdef REGFILE_BYPASS_EN
        if (!Rst && bus.Write_Enable && bus.rd != 0) begin
            if (bus.rs1 == bus.rd) begin e1 = bus.Write_Data; b1 = 1'b0; end
            if (bus.rs2 == bus.rd) begin e2 = bus.Write_Data; b2 = 1'b0; end
        end
`endif
        return {e1, e2, b1, b2, pa};
    endfunction

    function automatic logic [66:0] obs_main();
        return {bus.Rd1, bus.Rd2, bus.Busy1, bus.Busy2, bus.Pending_Any};
    endfunction

    task automatic test_reset();
        bus.Write_Enable = 1'b1; bus.rd = 5'd4; bus.Write_Data = 32'h1234;
        bus.Issue_Valid = 1'b1; bus.Issue_rd = 5'd6;
        tick();
        idle();
        bus.rs1 = 5'd4; bus.rs2 = 5'd6;
        #3;
        Rst = 1'b1;
        model_clear();
        #1;
        obs = obs_main();
        if (obs !== 67'd0) begin bad++; $display("FAIL reset_async: got %h want 0", obs); end
        total++;
        bus.Write_Enable = 1'b1; bus.rd = 5'd4; bus.Write_Data = 32'hFFFF_FFFF;
        bus.Issue_Valid = 1'b1; bus.Issue_rd = 5'd9;
        #1;
        obs = obs_main();
        if (obs !== 67'd0) begin bad++; $display("FAIL reset_nofwd: got %h want 0", obs); end
        total++;
        tick();
        bus.rs2 = 5'd9;
        #1;
        obs = obs_main();
        if (obs !== 67'd0) begin bad++; $display("FAIL reset_ignore: got %h want 0", obs); end
        total++;
        idle();
        Rst = 1'b0;
        bus.Write_Enable = 1'b1; bus.rd = 5'd0; bus.Write_Data = 32'hDEADBEEF;
        #1;
        if (bus.Rd1 !== 32'd0) begin bad++; $display("FAIL x0_same_cycle: got %h want 0", bus.Rd1); end
        total++;
        tick();
        idle();
        #1;
        if (bus.Rd1 !== 32'd0) begin bad++; $display("FAIL x0_after: got %h want 0", bus.Rd1); end
        total++;
    endtask

    task automatic test_basic();
        bus.Write_Enable = 1'b1; bus.rd = 5'd5; bus.Write_Data = 32'hA5A5A5A5;
        tick();
        bus.rd = 5'd10; bus.Write_Data = 32'h5A5A5A5A;
        tick();
        idle();
        bus.rs1 = 5'd5; bus.rs2 = 5'd10;
        #1;
        if (bus.Rd1 !== 32'hA5A5A5A5 || bus.Rd2 !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL basic_rw: got %h/%h want a5a5a5a5/5a5a5a5a", bus.Rd1, bus.Rd2);
        end
        total++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] want;
        bus.Write_Enable = 1'b1; bus.rd = 5'd15; bus.Write_Data = 32'h0000CAFE;
        tick();
        bus.Write_Data = 32'h12345678; bus.rs1 = 5'd15;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h12345678;
`else
        want = 32'h0000CAFE;
`endif
        if (bus.Rd1 !== want || bus.Busy1 !== 1'b0) begin
            bad++; $display("FAIL same_cycle: got %h busy %b want %h busy 0", bus.Rd1, bus.Busy1, want);
        end
        total++;
        tick();
        bus.Write_Enable = 1'b0;
        #1;
        if (bus.Rd1 !== 32'h12345678) begin
            bad++; $display("FAIL same_cycle_after: got %h want 12345678", bus.Rd1);
        end
        total++;
    endtask

    task automatic test_lifecycle();
        idle();
        bus.Issue_Valid = 1'b1; bus.Issue_rd = 5'd7; bus.rs1 = 5'd7;
        tick();
        bus.Issue_Valid = 1'b0;
        #1;
        if (bus.Busy1 !== 1'b1 || bus.Pending_Any !== 1'b1) begin
            bad++; $display("FAIL issue_busy: got %b/%b want 1/1", bus.Busy1, bus.Pending_Any);
        end
        total++;
        tick();
        tick();
        if (bus.Busy1 !== 1'b1) begin bad++; $display("FAIL busy_hold: got %b want 1", bus.Busy1); end
        total++;
        bus.Write_Enable = 1'b1; bus.rd = 5'd7; bus.Write_Data = 32'h1;
        #1;
        obs = obs_main(); exp_v = exp_main();
        if (obs !== exp_v) begin bad++; $display("FAIL wb_pre_edge: got %h want %h", obs, exp_v); end
        total++;
        tick();
        bus.Write_Enable = 1'b0;
        #1;
        if (bus.Busy1 !== 1'b0 || bus.Pending_Any !== 1'b0 || bus.Rd1 !== 32'h1) begin
            bad++; $display("FAIL wb_clear: got busy %b any %b rd %h want 0 0 1", bus.Busy1, bus.Pending_Any, bus.Rd1);
        end
        total++;
    endtask

    task automatic test_set_clr();
        idle();
        bus.Issue_Valid = 1'b1; bus.Issue_rd = 5'd3;
        bus.Write_Enable = 1'b1; bus.rd = 5'd3; bus.Write_Data = 32'h55; bus.rs1 = 5'd3;
        #1;
        obs = obs_main(); exp_v = exp_main();
        if (obs !== exp_v) begin bad++; $display("FAIL setclr_pre: got %h want %h", obs, exp_v); end
        total++;
        tick();
        bus.Issue_Valid = 1'b0; bus.Write_Enable = 1'b0;
        #1;
        if (bus.Rd1 !== 32'h55 || bus.Busy1 !== 1'b1) begin
            bad++; $display("FAIL setclr_after: got %h busy %b want 55 busy 1", bus.Rd1, bus.Busy1);
        end
        total++;
        bus.Write_Enable = 1'b1; bus.Write_Data = 32'h66;
        tick();
        bus.Write_Enable = 1'b0;
        #1;
        if (bus.Busy1 !== 1'b0 || bus.Rd1 !== 32'h66) begin
            bad++; $display("FAIL setclr_clear: got %h busy %b want 66 busy 0", bus.Rd1, bus.Busy1);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        idle();
        bus.Write_Enable = 1'b1; bus.rd = 5'd2; bus.Write_Data = 32'hFF;
        tick();
        bus.Write_Enable = 1'b0; bus.Issue_Valid = 1'b1; bus.Issue_rd = 5'd2;
        tick();
        bus.Issue_Valid = 1'b0; bus.rs1 = 5'd2; bus.rs2 = 5'd2;
        #1;
        if (bus.Rd1 !== 32'hFF || bus.Busy1 !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got %h busy %b want ff busy 1", bus.Rd1, bus.Busy1);
        end
        total++;
        #2;
        Rst = 1'b1;
        model_clear();
        #1;
        obs = obs_main();
        if (obs !== 67'd0) begin bad++; $display("FAIL reset_mid: got %h want 0", obs); end
        total++;
        tick();
        Rst = 1'b0;
        bus.Write_Enable = 1'b1; bus.rd = 5'd2; bus.Write_Data = 32'h3;
        tick();
        bus.Write_Enable = 1'b0;
        #1;
        if (bus.Rd1 !== 32'h3 || bus.Busy1 !== 1'b0) begin
            bad++; $display("FAIL post_reset_edge: got %h busy %b want 3 busy 0", bus.Rd1, bus.Busy1);
        end
        total++;
    endtask

    task automatic test_params();
        idle();
        bus2.Write_Enable = 1'b1; bus2.rd = 4'd5; bus2.Write_Data = 64'hA5A5A5A5_A5A5A5A5;
        tick();
        bus2.rd = 4'd10; bus2.Write_Data = 64'h5A5A5A5A_5A5A5A5A;
        tick();
        bus2.rd = 4'd15; bus2.Write_Data = 64'hF00D_0000_0000_BEEF;
        bus2.Issue_Valid = 1'b1; bus2.Issue_rd = 4'd15;
        tick();
        bus2.rd = 4'd0; bus2.Write_Data = 64'hFFFF_FFFF_FFFF_FFFF; bus2.Issue_Valid = 1'b0;
        tick();
        bus2.Write_Enable = 1'b0;
        bus2.rs1 = 4'd5; bus2.rs2 = 4'd10;
        #1;
        if (bus2.Rd1 !== 64'hA5A5A5A5_A5A5A5A5 || bus2.Rd2 !== 64'h5A5A5A5A_5A5A5A5A) begin
            bad++; $display("FAIL p64_basic: got %h/%h", bus2.Rd1, bus2.Rd2);
        end
        total++;
        bus2.rs1 = 4'd15; bus2.rs2 = 4'd0;
        #1;
        if (bus2.Rd1 !== m2_reg[15] || bus2.Busy1 !== m2_pend[15] || bus2.Rd2 !== 64'd0 ||
            bus2.Pending_Any !== 1'b1) begin
            bad++; $display("FAIL p64_top: got %h busy %b x0 %h any %b want %h busy %b",
                            bus2.Rd1, bus2.Busy1, bus2.Rd2, bus2.Pending_Any, m2_reg[15], m2_pend[15]);
        end
        total++;
    endtask

    task automatic test_random();
        logic [4:0] a;
        idle();
        for (int n = 0; n < 400; n++) begin
            a = 5'($urandom_range(0, 7));
            bus.Write_Enable = 1'($urandom);
            bus.rd           = ($urandom_range(0, 3) == 0) ? 5'($urandom) : a;
            bus.Write_Data   = $urandom;
            bus.Issue_Valid  = ($urandom_range(0, 2) == 0);
            bus.Issue_rd     = ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 7));
            bus.rs1          = ($urandom_range(0, 1) == 0) ? bus.rd : 5'($urandom_range(0, 7));
            bus.rs2          = 5'($urandom_range(0, 31));
            #1;
            obs = obs_main(); exp_v = exp_main();
            if (obs !== exp_v) begin
                bad++; $display("FAIL random[%0d]: got %h want %h", n, obs, exp_v);
            end
            total++;
            tick();
        end
        idle();
    endtask

    initial begin
        Rst = 1'b1;
        idle();
        model_clear();
        tick();
        tick();
        Rst = 1'b0;
        test_reset();
        test_basic();
        test_same_cycle();
        test_lifecycle();
        test_set_clr();
        test_reset_mid();
        test_params();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised integer register file with a built-in pending-write scoreboard, the next-generation replacement for the fixed 32×32 gate-level register file in the RV32I datapath. It provides two combinational read ports and one clocked write port. Register 0 is hardwired to zero. A per-register pending bit is set when an instruction issues with a destination and cleared when that destination is written back, so the pipeline can stall on RAW hazards. It sits between decode (read/issue) and writeback (write).

## Interface
- `DATA_W`, 32: register width in bits.
- `NUM_REGS`, 32: number of architectural registers; a power of two, ≥ 2.
- `ADDR_W`, $clog2(NUM_REGS): register index width.

- `Clk` in 1: single clock; all state updates on the rising edge.
- `Rst` in 1: reset, asynchronous and active-high.
- `rs1` in ADDR_W: read port 1 index.
- `rs2` in ADDR_W: read port 2 index.
- `Rd1` out DATA_W: read data for `rs1`.
- `Rd2` out DATA_W: read data for `rs2`.
- `Busy1` out 1: `rs1` has an outstanding write.
- `Busy2` out 1: `rs2` has an outstanding write.
- `Issue_Valid` in 1: an instruction with destination `Issue_rd` issues this cycle.
- `Issue_rd` in ADDR_W: destination being issued.
- `Write_Enable` in 1: writeback strobe.
- `rd` in ADDR_W: writeback destination.
- `Write_Data` in DATA_W: writeback data.
- `Pending_Any` out 1: OR of all pending bits.

## Operation
- Storage is `NUM_REGS` × `DATA_W` flops plus `NUM_REGS` pending bits. Entry 0 of each is constant 0 and has no flops.
- **Write:** on a rising edge with `Write_Enable`=1 and `rd`≠0, `reg[rd]` ← `Write_Data`. A write with `rd`=0 is discarded.
- **Read:** `Rd1` = `reg[rs1]` and `Rd2` = `reg[rs2]`, both combinational. Index 0 always reads 0.
- **Scoreboard, per register r≠0, evaluated at each rising edge:**
  - set = `Issue_Valid` & (`Issue_rd`==r)
  - clr = `Write_Enable` & (`rd`==r)
  - Next state: set → 1; else clr → 0; else hold.
  - When set and clr hit the same r in the same cycle, the bit stays 1, because the newer producer wins. The register data is still written.
- `Issue_rd`=0 never sets a bit. A clear of a bit that is already 0 has no effect; it is not an error.
- `Busy1` = `pending[rs1]` and `Busy2` = `pending[rs2]`, modified by bypass as described under Configuration. Both are 0 for index 0.
- `Pending_Any` is registered-state-derived and combinational: the OR of `pending[1..NUM_REGS-1]`.
- Index arithmetic is unsigned `ADDR_W` bits. There is no out-of-range index because `NUM_REGS` = 2^`ADDR_W`.

## Timing
- **Write-to-read latency without bypass:** data written at edge N is visible on `Rd*` after edge N. A same-cycle read returns the old value.
- **Issue-to-busy:** an issue at edge N makes `Busy*` go to 1 after edge N.
- **Writeback-to-not-busy:** a clear at edge N makes `Busy*` go to 0 after edge N, or combinationally before it when bypass is compiled in.
- **Reset, while `Rst`=1:**
  - All registers are 0 and all pending bits are 0.
  - `Rd1`, `Rd2`, `Busy1`, `Busy2` and `Pending_Any` are all 0.
  - Writes and issues are ignored.
- **Reset mid-operation:** asserting `Rst` between edges clears state immediately. The first edge after deassertion behaves as a normal cycle.
- There are no stalls or back-pressure inside the block; every input is sampled every cycle.

## Configuration
- **Macro:** `REGFILE_BYPASS_EN`.
- **Defined:** write-through forwarding.
  - When `Write_Enable`=1, `rd`≠0 and `rs1`==`rd`, `Rd1` = `Write_Data` and `Busy1` = 0 in the same cycle. `Rd2`/`Busy2` behave the same way for `rs2`.
  - For `Busy*` only, if `Issue_Valid`=1 and `Issue_rd` equals that same `rd`, the pending bit still reads 1 from the next cycle on.
  - Forwarding is gated off while `Rst`=1.
- **Undefined:** no forwarding. `Rd*` and `Busy*` reflect stored state only, and the pipeline must handle the one-cycle write-to-read gap.

## Test plan
- **Reset and x0:**
  - Pulse `Rst` asynchronously mid-cycle; all reads return 0 and `Pending_Any`=0.
  - Write 32'hDEADBEEF to `rd`=0, then read `rs1`=0 → 0.
- **Basic write/read:**
  - Write 32'hA5A5A5A5 to r5 and 32'h5A5A5A5A to r10 on consecutive edges.
  - Next cycle, `rs1`=5, `rs2`=10 → `Rd1`=A5A5A5A5, `Rd2`=5A5A5A5A.
- **Same-cycle read of write target:** `Write_Enable`=1, `rd`=15, `Write_Data`=32'h12345678, `rs1`=15.
  - With the macro defined: `Rd1`=12345678 and `Busy1`=0 before the edge.
  - Without it: `Rd1` holds the old value until after the edge.
- **Scoreboard lifecycle:**
  - Issue r7 at edge 1 → `Busy1`(`rs1`=7)=1 and `Pending_Any`=1.
  - Write r7=32'h1 at edge 4 → after edge 4, `Busy1`=0 and `Pending_Any`=0.
- **Simultaneous set and clear:** in one cycle, issue r3 and write r3=32'h55.
  - After the edge, `Rd1`(`rs1`=3)=55 and `Busy1`=1.
  - The next write to r3 clears it.
- **Reset mid-operation and parameters:**
  - With r2 pending and r2 holding 32'hFF, assert `Rst` → `Busy`=0 and `Rd`=0 immediately.
  - Re-run the basic write/read scenario with `DATA_W`=64 and `NUM_REGS`=16.
